framebuffer_scanout: RTL and testbench
======================================

Name: framebuffer_scanout

Overview:
Display-side reader of the double-buffered RGB565 framebuffer that the rasterizer writes. Generates raster timing (active area, porches, sync), issues one framebuffer read per active pixel, and outputs pixel/sync/data-enable aligned for the display PHY. Owns front-buffer selection: on request it swaps buffers at the start of vertical blanking, so the rasterizer always draws into the back buffer.

Parameters:
DISPLAY_WIDTH, 100, active pixels per line
DISPLAY_HEIGHT, 100, active lines per frame
H_FRONT, 4, horizontal front porch (cycles)
H_SYNC, 8, hsync width (cycles)
H_BACK, 4, horizontal back porch (cycles)
V_FRONT, 2, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 2, vertical back porch (lines)
FRAMEBUFFER_DATA_BITS, 16, RGB565 word width
FRAMEBUFFER_SIZE, DISPLAY_WIDTH*DISPLAY_HEIGHT, words per buffer
FRAMEBUFFER_ADDR_BITS, $clog2(FRAMEBUFFER_SIZE), per-buffer address width
READ_LATENCY, 1, cycles from fb_rd_addr to valid fb_rd_data (>=1)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-low reset (rst=0 resets)
fb_rd_en  out  1  read strobe, high only for active pixels
fb_rd_addr  out  FRAMEBUFFER_ADDR_BITS+1  {front_sel, x + DISPLAY_WIDTH*y} = front_sel*FRAMEBUFFER_SIZE + x + DISPLAY_WIDTH*y
fb_rd_data  in  FRAMEBUFFER_DATA_BITS  read data, READ_LATENCY cycles after address
swap_req  in  1  level; rasterizer requests buffer swap
swap_ack  out  1  one-cycle pulse when swap takes effect
front_sel  out  1  buffer currently displayed
out_r  out  5  pixel red (fb_rd_data[15:11])
out_g  out  6  pixel green ([10:5])
out_b  out  5  pixel blue ([4:0])
out_de  out  1  data enable, high for active pixels
out_hsync  out  1  active-high hsync
out_vsync  out  1  active-high vsync
frame_start  out  1  one-cycle pulse coincident with out_de for pixel (0,0)

Behaviour:
- H_TOTAL = DISPLAY_WIDTH+H_FRONT+H_SYNC+H_BACK. V_TOTAL analogous in lines. Internal counters h (0..H_TOTAL-1), v (0..V_TOTAL-1). h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
- Active: h<DISPLAY_WIDTH and v<DISPLAY_HEIGHT. Hsync region: h in [W+H_FRONT, W+H_FRONT+H_SYNC). Vsync region: v in [H+V_FRONT, H+V_FRONT+V_SYNC), whole lines.
- Reset (rst=0 at posedge): h=v=0, front_sel=0, fb_rd_en=0, fb_rd_addr=0, swap_ack=0, out_r/g/b=0, out_de=0, out_hsync=0, out_vsync=0, frame_start=0, pipeline contents cleared. Reset mid-frame aborts the frame immediately; no partial outputs afterward.
- First cycle after reset release: fb_rd_en=1, fb_rd_addr=0 (counters at (0,0)).
- fb_rd_en/fb_rd_addr are registered from counters; one address per cycle, raster order.
- Output latency: display outputs for a counter position appear exactly L=READ_LATENCY+1 cycles after that position's fb_rd_addr cycle. out_r/g/b are registered from fb_rd_data. de/hsync/vsync/frame_start are delayed through a matching shift register so all outputs stay aligned. When out_de=0, out_r/g/b=0.
- Swap: evaluated in the cycle counters sit at (W-1, H-1), the last active address. If swap_req=1 then, next cycle, front_sel toggles and swap_ack pulses for one cycle. Otherwise no change. All addresses in the next frame use the new front_sel. front_sel never changes mid-frame.
- Handshake: requester holds swap_req until it sees swap_ack, then drops it. If swap_req is still high at the next frame's evaluation point, another swap occurs (toggle every frame).
- swap_req asserted in the same cycle as the evaluation point counts for that frame.
- Counters free-run; no stall input. fb_rd_data is sampled unconditionally at latency.

Test Plan:
- W=4,H=3,H_FRONT=1,H_SYNC=2,H_BACK=1,V_* =1, READ_LATENCY=1, SIZE=12. Memory model returns data=addr. Hold rst=0 for 3 cycles -> all outputs 0; first cycle after release fb_rd_en=1, addr=0.
- Same config, line 0 -> addr 0,1,2,3 with en=1, then en=0 for 4 cycles, then 4..7. out_de high 4 cycles starting 2 cycles after addr 0, pixel={r,g,b}=0,1,2,3. frame_start is high with pixel 0 only.
- Same config -> out_hsync high 2 cycles, starting 5 cycles after each line's first out_de. out_vsync high for exactly one 8-cycle line, lines 4; frame period 48 cycles.
- swap_req=1 at frame cycle 10 -> swap_ack single pulse the cycle after addr 11 issues. Next frame addresses are 12..23 and front_sel=1. Drop swap_req after ack -> frame after also uses 12..23.
- swap_req held high across 3 frames -> front_sel toggles 0->1->0->1 with one swap_ack per frame. Base address alternates 0/12.
- Reset mid-line at addr 6 with front_sel=1 -> next cycle out_de=0, front_sel=0. After release, addr restarts at 0. Repeat line-0 check with READ_LATENCY=3 -> pixel/de/sync latency 4 cycles, still aligned.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster timing generator and framebuffer reader for a
// double-buffered RGB565 display. Issues one read per active pixel, then
// realigns read data with de/hsync/vsync/frame_start for the display PHY.
// Swaps the front buffer at the start of vertical blanking on request.
module framebuffer_scanout #(
  parameter int DISPLAY_WIDTH         = 100,
  parameter int DISPLAY_HEIGHT        = 100,
  parameter int H_FRONT               = 4,
  parameter int H_SYNC                = 8,
  parameter int H_BACK                = 4,
  parameter int V_FRONT               = 2,
  parameter int V_SYNC                = 2,
  parameter int V_BACK                = 2,
  parameter int FRAMEBUFFER_DATA_BITS = 16,
  parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE),
  parameter int READ_LATENCY          = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             fb_rd_en,
  output logic [FRAMEBUFFER_ADDR_BITS:0]   fb_rd_addr,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data,
  input  logic                             swap_req,
  output logic                             swap_ack,
  output logic                             front_sel,
  output logic [4:0]                       out_r,
  output logic [5:0]                       out_g,
  output logic [4:0]                       out_b,
  output logic                             out_de,
  output logic                             out_hsync,
  output logic                             out_vsync,
  output logic                             frame_start
);

  localparam int H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int AW = FRAMEBUFFER_ADDR_BITS + 1;
  // Buffer 1 starts right after buffer 0, which need not be a power of two.
  localparam logic [AW-1:0] BUF1_BASE = AW'(FRAMEBUFFER_SIZE);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [AW-1:0] pix;

  logic active, hs_now, vs_now, fs_now, at_last, h_wrap, v_wrap;

  logic de_s0, hs_s0, vs_s0, fs_s0;
  logic [READ_LATENCY-1:0] de_pipe, hs_pipe, vs_pipe, fs_pipe;

  // Decode the current raster position into region flags.
  always_comb begin
    active  = (int'(h) < DISPLAY_WIDTH) && (int'(v) < DISPLAY_HEIGHT);
    hs_now  = (int'(h) >= DISPLAY_WIDTH + H_FRONT) &&
              (int'(h) <  DISPLAY_WIDTH + H_FRONT + H_SYNC);
    vs_now  = (int'(v) >= DISPLAY_HEIGHT + V_FRONT) &&
              (int'(v) <  DISPLAY_HEIGHT + V_FRONT + V_SYNC);
    fs_now  = (h == '0) && (v == '0);
    at_last = (int'(h) == DISPLAY_WIDTH - 1) && (int'(v) == DISPLAY_HEIGHT - 1);
    h_wrap  = (int'(h) == H_TOTAL - 1);
    v_wrap  = (int'(v) == V_TOTAL - 1);
  end

  // Free-running raster counters plus a linear pixel index, which avoids a
  // multiplier for x + DISPLAY_WIDTH*y since active pixels are consecutive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h   <= '0;
      v   <= '0;
      pix <= '0;
    end else begin
      if (h_wrap) begin
        h <= '0;
        v <= v_wrap ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (h_wrap && v_wrap)
        pix <= '0;
      else if (active)
        pix <= pix + 1'b1;
    end
  end

  // Read request stage; the timing flags are registered alongside so they
  // share the address cycle as their time reference.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
      de_s0      <= 1'b0;
      hs_s0      <= 1'b0;
      vs_s0      <= 1'b0;
      fs_s0      <= 1'b0;
    end else begin
      fb_rd_en <= active;
      if (active)
        fb_rd_addr <= (front_sel ? BUF1_BASE : '0) + pix;
      de_s0 <= active;
      hs_s0 <= hs_now;
      vs_s0 <= vs_now;
      fs_s0 <= fs_now;
    end
  end

  // Buffer swap at the last active address; the address for that pixel still
  // uses the old front_sel, so the whole next frame reads the new buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      front_sel <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      swap_ack <= at_last && swap_req;
      if (at_last && swap_req)
        front_sel <= ~front_sel;
    end
  end

  // Delay line matching the memory read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      de_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
      fs_pipe <= '0;
    end else begin
      de_pipe[0] <= de_s0;
      hs_pipe[0] <= hs_s0;
      vs_pipe[0] <= vs_s0;
      fs_pipe[0] <= fs_s0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        de_pipe[i] <= de_pipe[i-1];
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        fs_pipe[i] <= fs_pipe[i-1];
      end
    end
  end

  // Output register: pixel data arrives together with the last pipe stage;
  // colour is forced to zero outside the active area.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_r       <= '0;
      out_g       <= '0;
      out_b       <= '0;
      out_de      <= 1'b0;
      out_hsync   <= 1'b0;
      out_vsync   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      out_de      <= de_pipe[READ_LATENCY-1];
      out_hsync   <= hs_pipe[READ_LATENCY-1];
      out_vsync   <= vs_pipe[READ_LATENCY-1];
      frame_start <= fs_pipe[READ_LATENCY-1];
      if (de_pipe[READ_LATENCY-1]) begin
        out_r <= fb_rd_data[15:11];
        out_g <= fb_rd_data[10:5];
        out_b <= fb_rd_data[4:0];
      end else begin
        out_r <= '0;
        out_g <= '0;
        out_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed bench for framebuffer_scanout on a 4x3
// display (H_TOTAL=8, V_TOTAL=6, 48-cycle frames). Memory returns data=addr.
// Instance a uses READ_LATENCY=1, instance b READ_LATENCY=3.
module tb_framebuffer_scanout;

  logic clk = 1'b0;
  logic rst;

  logic       en_a, swap_req_a, ack_a, fsel_a, de_a, hs_a, vs_a, fst_a;
  logic [4:0] addr_a;
  logic [15:0] data_a;
  logic [4:0] r_a, b_a;
  logic [5:0] g_a;

  logic       en_b, swap_req_b, ack_b, fsel_b, de_b, hs_b, vs_b, fst_b;
  logic [4:0] addr_b;
  logic [15:0] data_b;
  logic [4:0] r_b, b_b;
  logic [5:0] g_b;
  logic [4:0] mem_b1, mem_b2;

  int fc;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(3), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .FRAMEBUFFER_DATA_BITS(16),
    .FRAMEBUFFER_SIZE(12), .FRAMEBUFFER_ADDR_BITS(4), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .fb_rd_en(en_a), .fb_rd_addr(addr_a),
    .fb_rd_data(data_a), .swap_req(swap_req_a), .swap_ack(ack_a),
    .front_sel(fsel_a), .out_r(r_a), .out_g(g_a), .out_b(b_a),
    .out_de(de_a), .out_hsync(hs_a), .out_vsync(vs_a), .frame_start(fst_a)
  );

  framebuffer_scanout #(
    .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(3), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .FRAMEBUFFER_DATA_BITS(16),
    .FRAMEBUFFER_SIZE(12), .FRAMEBUFFER_ADDR_BITS(4), .READ_LATENCY(3)
  ) dut_b (
    .clk(clk), .rst(rst), .fb_rd_en(en_b), .fb_rd_addr(addr_b),
    .fb_rd_data(data_b), .swap_req(swap_req_b), .swap_ack(ack_b),
    .front_sel(fsel_b), .out_r(r_b), .out_g(g_b), .out_b(b_b),
    .out_de(de_b), .out_hsync(hs_b), .out_vsync(vs_b), .frame_start(fst_b)
  );

  // Memory models: data = address, after 1 and 3 cycles respectively.
  always @(posedge clk) begin
    data_a <= {11'd0, addr_a};
    mem_b1 <= addr_b;
    mem_b2 <= mem_b1;
    data_b <= {11'd0, mem_b2};
  end

  // Raster model indexed by frame cycle p (p=0 is pixel (0,0)).
  function automatic bit m_act(int p);
    if (p < 0) return 1'b0;
    return ((p % 8) < 4) && (((p % 48) / 8) < 3);
  endfunction
  function automatic bit m_hs(int p);
    if (p < 0) return 1'b0;
    return ((p % 8) >= 5) && ((p % 8) < 7);
  endfunction
  function automatic bit m_vs(int p);
    if (p < 0) return 1'b0;
    return ((p % 48) / 8) == 4;
  endfunction
  function automatic bit m_fs(int p);
    if (p < 0) return 1'b0;
    return (p % 48) == 0;
  endfunction
  function automatic int m_idx(int p);
    return ((p % 48) / 8) * 4 + (p % 8);
  endfunction

  task automatic tick();
    @(negedge clk);
    fc++;
  endtask

  // Leaves the bench at the negedge where fb_rd_addr 0 is visible (fc=0).
  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    swap_req_a = 1'b0;
    swap_req_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({en_a, addr_a, ack_a, fsel_a} !== 8'd0)
      $display("FAIL reset_req got en=%b addr=%0d ack=%b fsel=%b want all 0", en_a, addr_a, ack_a, fsel_a);
    else n_pass++;
    n_checks++;
    if ({r_a, g_a, b_a, de_a, hs_a, vs_a, fst_a} !== 20'd0)
      $display("FAIL reset_out got r=%0d g=%0d b=%0d de=%b hs=%b vs=%b fs=%b want all 0",
               r_a, g_a, b_a, de_a, hs_a, vs_a, fst_a);
    else n_pass++;
    n_checks++;
    if ({en_b, de_b, fsel_b} !== 3'd0)
      $display("FAIL reset_b got en=%b de=%b fsel=%b want 0", en_b, de_b, fsel_b);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    fc = 0;
    n_checks++;
    if (en_a !== 1'b1 || addr_a !== 5'd0)
      $display("FAIL first_after_release got en=%b addr=%0d want en=1 addr=0", en_a, addr_a);
    else n_pass++;
  endtask

  task automatic test_line0();
    logic [4:0] eb;
    do_reset();
    while (fc < 16) begin
      n_checks++;
      if (en_a !== m_act(fc))
        $display("FAIL line0_en fc=%0d got %b want %b", fc, en_a, m_act(fc));
      else n_pass++;
      if (m_act(fc)) begin
        n_checks++;
        if (addr_a !== 5'(m_idx(fc)))
          $display("FAIL line0_addr fc=%0d got %0d want %0d", fc, addr_a, m_idx(fc));
        else n_pass++;
      end
      n_checks++;
      if (de_a !== m_act(fc - 2))
        $display("FAIL line0_de fc=%0d got %b want %b", fc, de_a, m_act(fc - 2));
      else n_pass++;
      eb = m_act(fc - 2) ? 5'(m_idx(fc - 2)) : 5'd0;
      n_checks++;
      if (b_a !== eb || r_a !== 5'd0 || g_a !== 6'd0)
        $display("FAIL line0_pixel fc=%0d got r=%0d g=%0d b=%0d want 0 0 %0d", fc, r_a, g_a, b_a, eb);
      else n_pass++;
      n_checks++;
      if (fst_a !== m_fs(fc - 2))
        $display("FAIL line0_frame_start fc=%0d got %b want %b", fc, fst_a, m_fs(fc - 2));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_sync();
    do_reset();
    while (fc < 100) begin
      n_checks++;
      if (hs_a !== m_hs(fc - 2))
        $display("FAIL sync_hsync fc=%0d got %b want %b", fc, hs_a, m_hs(fc - 2));
      else n_pass++;
      n_checks++;
      if (vs_a !== m_vs(fc - 2))
        $display("FAIL sync_vsync fc=%0d got %b want %b", fc, vs_a, m_vs(fc - 2));
      else n_pass++;
      n_checks++;
      if (de_a !== m_act(fc - 2) || fst_a !== m_fs(fc - 2))
        $display("FAIL sync_de_fs fc=%0d got de=%b fs=%b want de=%b fs=%b",
                 fc, de_a, fst_a, m_act(fc - 2), m_fs(fc - 2));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_swap();
    logic       e_fs, e_ack;
    logic [4:0] e_addr;
    do_reset();
    while (fc < 144) begin
      if (fc == 10) swap_req_a = 1'b1;
      e_fs  = (fc >= 19);
      e_ack = (fc == 19);
      n_checks++;
      if (ack_a !== e_ack || fsel_a !== e_fs)
        $display("FAIL swap_ack_fsel fc=%0d got ack=%b fsel=%b want ack=%b fsel=%b", fc, ack_a, fsel_a, e_ack, e_fs);
      else n_pass++;
      if (m_act(fc)) begin
        e_addr = 5'(((fc >= 48) ? 12 : 0) + m_idx(fc));
        n_checks++;
        if (en_a !== 1'b1 || addr_a !== e_addr)
          $display("FAIL swap_addr fc=%0d got en=%b addr=%0d want en=1 addr=%0d", fc, en_a, addr_a, e_addr);
        else n_pass++;
      end
      if (ack_a) swap_req_a = 1'b0;
      tick();
    end
    swap_req_a = 1'b0;
  endtask

  task automatic test_swap_hold();
    logic       e_fs, e_ack;
    logic [4:0] e_addr;
    int         nsw;
    do_reset();
    swap_req_a = 1'b1;
    while (fc < 192) begin
      nsw   = (fc >= 19) ? ((fc - 19) / 48 + 1) : 0;
      e_fs  = nsw[0];
      e_ack = ((fc % 48) == 19);
      n_checks++;
      if (ack_a !== e_ack || fsel_a !== e_fs)
        $display("FAIL hold_ack_fsel fc=%0d got ack=%b fsel=%b want ack=%b fsel=%b", fc, ack_a, fsel_a, e_ack, e_fs);
      else n_pass++;
      if (m_act(fc)) begin
        e_addr = 5'((((fc / 48) % 2) == 1 ? 12 : 0) + m_idx(fc));
        n_checks++;
        if (addr_a !== e_addr)
          $display("FAIL hold_addr fc=%0d got %0d want %0d", fc, addr_a, e_addr);
        else n_pass++;
      end
      tick();
    end
    swap_req_a = 1'b0;
  endtask

  task automatic test_midreset();
    do_reset();
    swap_req_a = 1'b1;
    while (fc < 58) begin
      tick();
      if (ack_a) swap_req_a = 1'b0;
    end
    swap_req_a = 1'b0;
    n_checks++;
    if (addr_a !== 5'd18 || fsel_a !== 1'b1 || de_a !== 1'b1)
      $display("FAIL midrst_pre got addr=%0d fsel=%b de=%b want 18 1 1", addr_a, fsel_a, de_a);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (de_a !== 1'b0 || fsel_a !== 1'b0 || en_a !== 1'b0 || addr_a !== 5'd0 || b_a !== 5'd0)
      $display("FAIL midrst_cleared got de=%b fsel=%b en=%b addr=%0d b=%0d want all 0",
               de_a, fsel_a, en_a, addr_a, b_a);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fc = 0;
    n_checks++;
    if (en_a !== 1'b1 || addr_a !== 5'd0 || de_a !== 1'b0)
      $display("FAIL midrst_restart got en=%b addr=%0d de=%b want 1 0 0", en_a, addr_a, de_a);
    else n_pass++;
    tick();
    n_checks++;
    if (de_a !== 1'b0 || addr_a !== 5'd1)
      $display("FAIL midrst_no_partial got de=%b addr=%0d want de=0 addr=1", de_a, addr_a);
    else n_pass++;
  endtask

  task automatic test_latency3();
    logic [4:0] eb;
    do_reset();
    while (fc < 16) begin
      if (m_act(fc)) begin
        n_checks++;
        if (en_b !== 1'b1 || addr_b !== 5'(m_idx(fc)))
          $display("FAIL lat3_addr fc=%0d got en=%b addr=%0d want en=1 addr=%0d", fc, en_b, addr_b, m_idx(fc));
        else n_pass++;
      end
      n_checks++;
      if (de_b !== m_act(fc - 4) || hs_b !== m_hs(fc - 4) || fst_b !== m_fs(fc - 4))
        $display("FAIL lat3_timing fc=%0d got de=%b hs=%b fs=%b want de=%b hs=%b fs=%b",
                 fc, de_b, hs_b, fst_b, m_act(fc - 4), m_hs(fc - 4), m_fs(fc - 4));
      else n_pass++;
      eb = m_act(fc - 4) ? 5'(m_idx(fc - 4)) : 5'd0;
      n_checks++;
      if (b_b !== eb || r_b !== 5'd0 || g_b !== 6'd0)
        $display("FAIL lat3_pixel fc=%0d got r=%0d g=%0d b=%0d want 0 0 %0d", fc, r_b, g_b, b_b, eb);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    swap_req_a = 1'b0;
    swap_req_b = 1'b0;
    fc = 0;
    test_reset();
    test_line0();
    test_sync();
    test_swap();
    test_swap_hold();
    test_midreset();
    test_latency3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
